// File: rtl/mem_lsu.sv
// Load/store unit in front of a synchronous word RAM: byte/half/word accesses,
// sub-word stores via read-modify-write, alignment errors answered without RAM access.
module mem_lsu #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              Mem_Read,
  output logic              Mem_Write,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [31:0]       M_W_Data,
  input  logic [31:0]       M_R_Data,
  output logic [2:0]        dbg_state
);

  // Handshake: a request is accepted on a rising edge where req_valid && req_ready;
  // req_ready is high only in IDLE and rsp_valid is a one-cycle pulse with no backpressure.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_READ    = 3'd1,
    S_CAPTURE = 3'd2,
    S_WRITE   = 3'd3,
    S_RESP    = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              signed_q, signed_d;
  logic [ADDR_W+1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              req_bad;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;
  logic [31:0]       load_ext;
  logic [31:0]       merged;

  assign req_bad = (req_size == 2'b11) ||
                   (req_size == 2'b01 && req_addr[0]) ||
                   (req_size == 2'b10 && req_addr[1:0] != 2'b00);

  // Lane selection and extension of the RAM word for loads.
  always_comb begin
    rd_byte  = 8'h00;
    rd_half  = addr_q[1] ? M_R_Data[31:16] : M_R_Data[15:0];
    load_ext = M_R_Data;
    case (addr_q[1:0])
      2'd0:    rd_byte = M_R_Data[7:0];
      2'd1:    rd_byte = M_R_Data[15:8];
      2'd2:    rd_byte = M_R_Data[23:16];
      default: rd_byte = M_R_Data[31:24];
    endcase
    case (size_q)
      2'b00:   load_ext = {{24{signed_q & rd_byte[7]}}, rd_byte};
      2'b01:   load_ext = {{16{signed_q & rd_half[15]}}, rd_half};
      default: load_ext = M_R_Data;
    endcase
  end

  // Sub-word store merge: only the addressed lane of the old word is replaced.
  always_comb begin
    merged = M_R_Data;
    case (size_q)
      2'b00: begin
        case (addr_q[1:0])
          2'd0:    merged[7:0]   = wdata_q[7:0];
          2'd1:    merged[15:8]  = wdata_q[7:0];
          2'd2:    merged[23:16] = wdata_q[7:0];
          default: merged[31:24] = wdata_q[7:0];
        endcase
      end
      2'b01: begin
        if (addr_q[1]) merged[31:16] = wdata_q[15:0];
        else           merged[15:0]  = wdata_q[15:0];
      end
      default: merged = wdata_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    size_d   = size_q;
    signed_d = signed_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d     = req_we;
          size_d   = req_size;
          signed_d = req_signed;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          rdata_d  = 32'h0;
          err_d    = 1'b0;
          if (req_bad) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end else if (req_we && req_size == 2'b10) begin
            state_d = S_WRITE;
          end else begin
            state_d = S_READ;
          end
        end
      end
      S_READ: state_d = S_CAPTURE;
      S_CAPTURE: begin
        if (we_q) begin
          wdata_d = merged;
          state_d = S_WRITE;
        end else begin
          rdata_d = load_ext;
          state_d = S_RESP;
        end
      end
      S_WRITE: state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      we_q     <= 1'b0;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= 32'h0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // All RAM-side outputs decode from registered state only.
  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rsp_valid ? rdata_q : 32'h0;
  assign rsp_err   = rsp_valid & err_q;
  assign Mem_Read  = (state_q == S_READ);
  assign Mem_Write = (state_q == S_WRITE);
  assign Mem_Addr  = (Mem_Read || Mem_Write) ? addr_q[ADDR_W+1:2] : '0;
  assign M_W_Data  = Mem_Write ? wdata_q : 32'h0;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: behavioural 64x32 synchronous RAM, vector table, expected-response
// queue, and hand-written back-to-back and mid-transaction reset sequences.
module tb_mem_lsu;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        Mem_Read;
  logic        Mem_Write;
  logic [5:0]  Mem_Addr;
  logic [31:0] M_W_Data;
  logic [31:0] M_R_Data;
  logic [2:0]  dbg_state;

  mem_lsu #(.ADDR_W(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .Mem_Read(Mem_Read), .Mem_Write(Mem_Write), .Mem_Addr(Mem_Addr),
    .M_W_Data(M_W_Data), .M_R_Data(M_R_Data), .dbg_state(dbg_state)
  );

  // clock / RAM model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] ram [64];
  always @(posedge clk) begin
    if (Mem_Write) ram[Mem_Addr] <= M_W_Data;
    if (Mem_Read)  M_R_Data <= ram[Mem_Addr];
  end

  // scoreboard: {err, rdata}
  logic [32:0] exp_q[$];
  int tests = 0;
  int fails = 0;
  logic [31:0] ref_mem [8:15];

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          nrd;
    int          nwr;
    logic [31:0] wd;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // per-cycle invariants sampled at negedge
  task automatic cycle_checks(input string tag);
    if (Mem_Read && Mem_Write) begin
      fails++;
      $display("FAIL %s mem_rd_wr_both actual=1 required=0", tag);
    end
    if (!rsp_valid && (rsp_rdata != 32'h0 || rsp_err)) begin
      fails++;
      $display("FAIL %s rsp_idle_zero actual=%h/%b required=0/0", tag, rsp_rdata, rsp_err);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] sz,
                                             input logic [1:0] off, input logic sgn);
    logic [31:0] sh;
    sh = w >> (int'(off) * 8);
    case (sz)
      2'b00:   return sgn ? {{24{sh[7]}}, sh[7:0]} : {24'h0, sh[7:0]};
      2'b01:   return sgn ? {{16{sh[15]}}, sh[15:0]} : {16'h0, sh[15:0]};
      default: return w;
    endcase
  endfunction

  task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [7:0] addr, input logic [31:0] wdata,
                        input int exp_lat, input int exp_rd, input int exp_wr,
                        input logic [31:0] exp_wd, input string tag);
    int lat;
    int nrd;
    int nwr;
    logic [31:0] wd;
    logic [5:0]  wa;
    logic [32:0] e;
    lat = 0; nrd = 0; nwr = 0; wd = 32'h0; wa = 6'h0;
    req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      cycle_checks(tag);
      if (Mem_Read) nrd++;
      if (Mem_Write) begin nwr++; wd = M_W_Data; wa = Mem_Addr; end
      if (rsp_valid) begin lat = k; break; end
    end
    e = exp_q.pop_front();
    if (lat == 0) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      check({tag, "_rsp"}, {rsp_err, rsp_rdata[30:0]} ^ {31'h0, rsp_rdata[31]} ^ {31'h0, rsp_rdata[31]},
            {e[32], e[30:0]});
      check({tag, "_rdata"}, rsp_rdata, e[31:0]);
      check({tag, "_lat"}, lat, exp_lat);
      check({tag, "_nrd"}, nrd, exp_rd);
      check({tag, "_nwr"}, nwr, exp_wr);
      if (nwr > 0) begin
        check({tag, "_wdata"}, wd, exp_wd);
        check({tag, "_waddr"}, {26'h0, wa}, {26'h0, addr[7:2]});
      end
    end
  endtask

  initial begin
    int ready_low;
    int hs;
    int hs_cyc [2];
    int rsp_cnt;
    logic prev_rsp;
    logic [32:0] e;
    logic [1:0] sz;
    logic [1:0] off;
    logic sgn;
    int idx;

    vecs[0]  = '{1'b1, 2'b10, 1'b0, 8'h10, 32'hDEADBEEF, 1'b0, 32'h0,        2, 0, 1, 32'hDEADBEEF};
    vecs[1]  = '{1'b0, 2'b10, 1'b0, 8'h10, 32'h0,        1'b0, 32'hDEADBEEF, 3, 1, 0, 32'h0};
    vecs[2]  = '{1'b1, 2'b00, 1'b0, 8'h11, 32'h000000AA, 1'b0, 32'h0,        4, 1, 1, 32'hDEADAAEF};
    vecs[3]  = '{1'b0, 2'b00, 1'b1, 8'h11, 32'h0,        1'b0, 32'hFFFFFFAA, 3, 1, 0, 32'h0};
    vecs[4]  = '{1'b0, 2'b00, 1'b0, 8'h11, 32'h0,        1'b0, 32'h000000AA, 3, 1, 0, 32'h0};
    vecs[5]  = '{1'b1, 2'b01, 1'b0, 8'h12, 32'h00008234, 1'b0, 32'h0,        4, 1, 1, 32'h8234AAEF};
    vecs[6]  = '{1'b0, 2'b01, 1'b1, 8'h12, 32'h0,        1'b0, 32'hFFFF8234, 3, 1, 0, 32'h0};
    vecs[7]  = '{1'b0, 2'b01, 1'b0, 8'h12, 32'h0,        1'b0, 32'h00008234, 3, 1, 0, 32'h0};
    vecs[8]  = '{1'b1, 2'b10, 1'b0, 8'h11, 32'h12345678, 1'b1, 32'h0,        1, 0, 0, 32'h0};
    vecs[9]  = '{1'b0, 2'b01, 1'b1, 8'h13, 32'h0,        1'b1, 32'h0,        1, 0, 0, 32'h0};
    vecs[10] = '{1'b0, 2'b11, 1'b0, 8'h00, 32'h0,        1'b1, 32'h0,        1, 0, 0, 32'h0};
    vecs[11] = '{1'b0, 2'b10, 1'b0, 8'h10, 32'h0,        1'b0, 32'h8234AAEF, 3, 1, 0, 32'h0};

    // reset block
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = 8'h0; req_wdata = 32'h0;
    #3;
    check("rst_ready", {31'h0, req_ready}, 32'd1);
    check("rst_outs", {28'h0, rsp_valid, rsp_err, Mem_Read, Mem_Write}, 32'd0);
    check("rst_addr_data", {26'h0, Mem_Addr} | M_W_Data | rsp_rdata, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // vector table
    for (int i = 0; i < 12; i++) begin
      exp_q.push_back({vecs[i].err, vecs[i].rdata});
      do_req(vecs[i].we, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata,
             vecs[i].lat, vecs[i].nrd, vecs[i].nwr, vecs[i].wd, $sformatf("vec%0d", i));
      @(negedge clk);
    end

    // random word fill then random aligned loads against a reference copy
    for (int w = 8; w <= 15; w++) begin
      ref_mem[w] = $urandom;
      exp_q.push_back({1'b0, 32'h0});
      do_req(1'b1, 2'b10, 1'b0, 8'(w * 4), ref_mem[w], 2, 0, 1, ref_mem[w], $sformatf("fill%0d", w));
      @(negedge clk);
    end
    for (int n = 0; n < 12; n++) begin
      idx = $urandom_range(8, 15);
      sz  = 2'($urandom_range(0, 2));
      sgn = 1'($urandom_range(0, 1));
      off = 2'($urandom_range(0, 3));
      if (sz == 2'b01) off[0] = 1'b0;
      if (sz == 2'b10) off = 2'b00;
      exp_q.push_back({1'b0, model_load(ref_mem[idx], sz, off, sgn)});
      do_req(1'b0, sz, sgn, {idx[5:0], off}, 32'h0, 3, 1, 0, 32'h0, $sformatf("rnd%0d", n));
      @(negedge clk);
    end

    // back-to-back loads with req_valid held high
    exp_q.push_back({1'b0, 32'h8234AAEF});
    exp_q.push_back({1'b0, 32'h8234AAEF});
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_addr = 8'h10;
    hs = 0; ready_low = 0; rsp_cnt = 0; prev_rsp = 1'b0;
    hs_cyc[0] = 0; hs_cyc[1] = 0;
    for (int i = 0; i < 14; i++) begin
      if (req_valid && req_ready && hs < 2) begin hs_cyc[hs] = i; hs++; end
      @(negedge clk);
      cycle_checks("b2b");
      if (hs == 2) req_valid = 1'b0;
      if (hs == 1 && !req_ready) ready_low++;
      if (rsp_valid) begin
        rsp_cnt++;
        e = exp_q.pop_front();
        check("b2b_rdata", rsp_rdata, e[31:0]);
        if (prev_rsp) check("b2b_pulse_width", 32'd2, 32'd1);
      end
      prev_rsp = rsp_valid;
    end
    req_valid = 1'b0;
    check("b2b_handshakes", hs, 2);
    check("b2b_gap", hs_cyc[1] - hs_cyc[0], 4);
    check("b2b_ready_low", ready_low, 3);
    check("b2b_rsp_cnt", rsp_cnt, 2);
    while (exp_q.size() > 0) void'(exp_q.pop_front());

    // reset during CAPTURE of a load
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 8'h10;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("rstmid_state", {29'h0, dbg_state}, 32'd2);
    rst_n = 1'b0;
    #1;
    check("rstmid_ready", {31'h0, req_ready}, 32'd1);
    check("rstmid_outs", {30'h0, rsp_valid, Mem_Read | Mem_Write}, 32'd0);
    check("rstmid_addr_data", {26'h0, Mem_Addr} | M_W_Data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rsp_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rsp_valid) rsp_cnt++;
    end
    check("rstmid_no_rsp", rsp_cnt, 0);
    exp_q.push_back({1'b0, 32'h8234AAEF});
    do_req(1'b0, 2'b10, 1'b0, 8'h10, 32'h0, 3, 1, 0, 32'h0, "post_rst");
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
